calc_cmd_parser: RTL and testbench
==================================

Name: calc_cmd_parser

Overview:
- Parametrised successor to the UART calculator command decoder; sits between the UART receiver and the ALU.
- Parses ASCII command frames of the form "I <type> <operand1> <op> <operand2> =".
- Operands are variable-length hex, up to DIGITS digits each. Whitespace is tolerated around the operator and the '='.
- Adds a ready/valid result handshake, error reporting with codes, resynchronisation after errors, and an optional inter-byte timeout.

Parameters:
- DIGITS, 4, maximum hex digits per operand (1..8). Operand width OPW = 4*DIGITS is a derived localparam, not overridable.
- TIMEOUT, 0, idle cycles allowed between bytes mid-frame; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe; rx_data is consumed in that cycle
- cmd_valid  out  1  parsed command available
- cmd_ready  in  1  consumer accepts the command
- dtype  out  2  01=signed 'S', 10=unsigned 'U'
- operator  out  3  001 '+', 010 '-', 011 '*', 100 '/'
- src1  out  OPW  operand 1, right-aligned
- src2  out  OPW  operand 2, right-aligned
- err_valid  out  1  one-cycle error pulse
- err_code  out  3  error cause; valid while err_valid is high
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, active-high, clk is the only clock):
  - state=IDLE; every output is 0; digit counter and timeout counter are 0.
  - Reset mid-frame abandons the frame with no error pulse.
- Hex digits: '0'-'9', 'A'-'F', 'a'-'f'.
- SP = 0x20. Operator characters: 0x2B '+', 0x2D '-', 0x2A '*', 0x2F '/'.
- State machine. Transitions occur only on rx_valid, except in DONE and ERR and on timeout.
  - IDLE:
    - 'I' (0x49): clear src1, src2 and the digit count; go to SP1.
    - SP, CR (0x0D), LF (0x0A): ignored.
    - Anything else: ERR with code 1 (BAD_FORMAT).
  - SP1: SP -> TYPE; else ERR code 1.
  - TYPE:
    - 'S'/'s' sets dtype=01; 'U'/'u' sets dtype=10; go to SP2.
    - Else ERR code 2 (BAD_TYPE).
  - SP2: SP -> OP1; else ERR code 1.
  - OP1:
    - Hex digit: src1 <= {src1[OPW-5:0], nibble}; cnt+1.
    - If cnt already equals DIGITS, the digit is not shifted: ERR code 3 (OVERFLOW).
    - SP with cnt=0: ignored. SP with cnt>0: go to OPER.
    - Operator with cnt>0: latch operator, clear cnt, go to OP2.
    - Anything else, including an operator with cnt=0: ERR code 4 (BAD_CHAR).
  - OPER:
    - SP ignored.
    - Operator: latch operator, clear cnt, go to OP2.
    - Else ERR code 4.
  - OP2:
    - Hex digit: shift into src2 with the same overflow rule as OP1 (code 3).
    - SP: ignored if cnt=0; go to EQ if cnt>0.
    - '=' (0x3D) with cnt>0: go to DONE.
    - '=' with cnt=0, or any other byte: ERR code 4.
  - EQ: SP ignored; '=' -> DONE; else ERR code 4.
  - DONE:
    - cmd_valid=1; dtype, operator, src1 and src2 are held stable.
    - cmd_ready=1: return to IDLE the next cycle.
    - rx_valid while cmd_ready=0: byte dropped; err_valid pulse with code 5 (OVERRUN); command retained.
    - rx_valid and cmd_ready in the same cycle: handshake completes and the byte is processed under IDLE rules, with no overrun.
  - ERR:
    - Entered the cycle after the offending byte. err_valid=1 and err_code are driven for exactly that one cycle.
    - Subsequent bytes are discarded until '=' or LF, then return to IDLE.
- Timeout (TIMEOUT>0):
  - In SP1..EQ the counter increments each cycle without rx_valid and clears on rx_valid.
  - When the counter reaches TIMEOUT: err_valid pulse with code 6 (TIMEOUT); go directly to IDLE, skipping ERR.
- Latency:
  - cmd_valid rises on the cycle after the '=' byte.
  - err_valid rises on the cycle after the offending byte or timeout.
- Leading zeros count toward DIGITS.
- Outside DONE, dtype/operator/src1/src2 may change during parsing and are meaningful only while cmd_valid=1.
- Operand values are passed through unchanged. Sign interpretation and arithmetic belong downstream.

Test Plan:
- DIGITS=4, bytes "I S 1A2B+0003=", cmd_ready=1 -> cmd_valid one cycle after '='; dtype=01, operator=001, src1=16'h1A2B, src2=16'h0003; busy low the following cycle.
- Bytes "I u 7  *  f =" -> dtype=10, operator=011, src1=16'h0007, src2=16'h000F; no err_valid.
- Bytes "I S 12345" -> err_valid with err_code=3 on the cycle after '5'. Then "9=" is discarded until '='. Then "I U 1/2=" parses with src1=1, src2=2, operator=100.
- Frame completes with cmd_ready=0 held 10 cycles; send 'I' during the wait -> err_code=5 pulse; fields unchanged. Assert cmd_ready -> IDLE next cycle.
- TIMEOUT=100, send "I S 12" then stall -> err_code=6 pulse exactly 100 cycles after '2'; busy=0 the next cycle.
- Assert rst for one cycle during OP2 -> the next cycle all outputs are 0 and busy=0. A following "I S F-1=" gives src1=16'h000F, src2=16'h0001, operator=010.

Source files
------------

// File: rtl/calc_cmd_parser_if.sv
// Purpose: byte-in / command-out bundle between the UART receiver, the command parser and the ALU.
// Latency: wiring only, no state.
// Backpressure: the command side uses cmd_valid/cmd_ready. The byte side has no ready; rx_valid is a one-cycle strobe.
//
// Signals:
//   rx_data/rx_valid          byte stream from the UART receiver
//   cmd_valid/cmd_ready       parsed-command handshake toward the ALU
//   dtype/operator/src1/src2  command fields, meaningful while cmd_valid=1
//   err_valid/err_code        one-cycle error report
//   busy                      parser is inside a frame (or holding a result/error)
// Modports: slave = the parser (consumes bytes, sources commands); master = its environment.
interface calc_cmd_parser_if #(
  parameter int DIGITS = 4
);
  localparam int OPW = 4 * DIGITS;

  logic [7:0]     rx_data;
  logic           rx_valid;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     dtype;
  logic [2:0]     operator;
  logic [OPW-1:0] src1;
  logic [OPW-1:0] src2;
  logic           err_valid;
  logic [2:0]     err_code;
  logic           busy;

  modport slave (
    input  rx_data, rx_valid, cmd_ready,
    output cmd_valid, dtype, operator, src1, src2, err_valid, err_code, busy
  );

  modport master (
    output rx_data, rx_valid, cmd_ready,
    input  cmd_valid, dtype, operator, src1, src2, err_valid, err_code, busy
  );
endinterface

// File: rtl/calc_cmd_parser.sv
// Purpose: parses ASCII frames "I <type> <hex> <op> <hex> =" into calculator commands for the ALU.
// Latency: cmd_valid and err_valid rise the cycle after the '=' byte or the offending byte.
// Backpressure: a result is held in DONE until cmd_ready. Bytes arriving while it is held are dropped and flagged as OVERRUN.
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   bus (slave)      rx_data/rx_valid in; cmd_valid/cmd_ready handshake;
//                    dtype, operator, src1, src2, err_valid, err_code, busy out
// Parameters: DIGITS = maximum hex digits per operand (1..8).
//             TIMEOUT = idle cycles allowed between bytes mid-frame (0 = disabled).
module calc_cmd_parser #(
  parameter int DIGITS  = 4,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             rst,
  calc_cmd_parser_if.slave bus
);

  localparam int OPW = 4 * DIGITS;
  localparam int CW  = $clog2(DIGITS + 1);
  localparam int TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [CW-1:0] CNT_MAX = CW'(DIGITS);
  // The timeout fires on the TIMEOUT-th consecutive idle cycle, so compare against TIMEOUT-1.
  localparam logic [TW-1:0] T_LAST  = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  // Characters
  localparam logic [7:0] CH_SP = 8'h20;
  localparam logic [7:0] CH_CR = 8'h0D;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_I  = 8'h49;
  localparam logic [7:0] CH_EQ = 8'h3D;
  localparam logic [7:0] CH_SU = 8'h53;  // 'S'
  localparam logic [7:0] CH_SL = 8'h73;  // 's'
  localparam logic [7:0] CH_UU = 8'h55;  // 'U'
  localparam logic [7:0] CH_UL = 8'h75;  // 'u'

  // Error codes
  localparam logic [2:0] E_FORMAT  = 3'd1;
  localparam logic [2:0] E_TYPE    = 3'd2;
  localparam logic [2:0] E_OVF     = 3'd3;
  localparam logic [2:0] E_CHAR    = 3'd4;
  localparam logic [2:0] E_OVERRUN = 3'd5;
  localparam logic [2:0] E_TIMEOUT = 3'd6;

  localparam logic [1:0] DT_SIGNED   = 2'b01;
  localparam logic [1:0] DT_UNSIGNED = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE, S_SP1, S_TYPE, S_SP2, S_OP1, S_OPER, S_OP2, S_EQ, S_DONE, S_ERR
  } state_t;

  state_t         state, state_nxt;
  logic [OPW-1:0] src1, src1_nxt;
  logic [OPW-1:0] src2, src2_nxt;
  logic [1:0]     dtype, dtype_nxt;
  logic [2:0]     oper, oper_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [TW-1:0]  tcnt, tcnt_nxt;
  logic           err_vld, err_vld_nxt;
  logic [2:0]     err_code, err_code_nxt;

  // Byte classification
  logic [7:0] d;
  logic       is_hex, is_sp, is_op;
  logic [3:0] nib;
  logic [2:0] op_code;

  assign d = bus.rx_data;

  always_comb begin
    is_hex  = 1'b0;
    nib     = 4'd0;
    is_op   = 1'b1;
    op_code = 3'd0;
    if (d >= 8'h30 && d <= 8'h39) begin
      is_hex = 1'b1;
      nib    = d[3:0];
    end else if ((d >= 8'h41 && d <= 8'h46) || (d >= 8'h61 && d <= 8'h66)) begin
      // 'A'..'F' and 'a'..'f' both have 1..6 in the low nibble.
      is_hex = 1'b1;
      nib    = d[3:0] + 4'd9;
    end
    case (d)
      8'h2B:   op_code = 3'b001;  // '+'
      8'h2D:   op_code = 3'b010;  // '-'
      8'h2A:   op_code = 3'b011;  // '*'
      8'h2F:   op_code = 3'b100;  // '/'
      default: is_op   = 1'b0;
    endcase
  end

  assign is_sp = (d == CH_SP);

  // Next-state and datapath
  logic       idle_rules;  // process the current byte with IDLE semantics
  logic       bad;
  logic [2:0] bad_code;

  always_comb begin
    state_nxt    = state;
    src1_nxt     = src1;
    src2_nxt     = src2;
    dtype_nxt    = dtype;
    oper_nxt     = oper;
    cnt_nxt      = cnt;
    tcnt_nxt     = '0;
    err_vld_nxt  = 1'b0;
    err_code_nxt = 3'd0;
    idle_rules   = 1'b0;
    bad          = 1'b0;
    bad_code     = 3'd0;

    case (state)
      S_IDLE: idle_rules = bus.rx_valid;

      S_DONE: begin
        if (bus.cmd_ready) begin
          // The handshake completes, and a byte arriving in the same cycle
          // is the start of the next frame rather than an overrun.
          state_nxt  = S_IDLE;
          idle_rules = bus.rx_valid;
        end else if (bus.rx_valid) begin
          err_vld_nxt  = 1'b1;
          err_code_nxt = E_OVERRUN;
        end
      end

      S_ERR: begin
        if (bus.rx_valid && (d == CH_EQ || d == CH_LF)) state_nxt = S_IDLE;
      end

      default: begin
        if (bus.rx_valid) begin
          case (state)
            S_SP1: begin
              if (is_sp) state_nxt = S_TYPE;
              else begin bad = 1'b1; bad_code = E_FORMAT; end
            end

            S_TYPE: begin
              if (d == CH_SU || d == CH_SL) begin
                dtype_nxt = DT_SIGNED;
                state_nxt = S_SP2;
              end else if (d == CH_UU || d == CH_UL) begin
                dtype_nxt = DT_UNSIGNED;
                state_nxt = S_SP2;
              end else begin
                bad = 1'b1; bad_code = E_TYPE;
              end
            end

            S_SP2: begin
              if (is_sp) state_nxt = S_OP1;
              else begin bad = 1'b1; bad_code = E_FORMAT; end
            end

            S_OP1: begin
              if (is_hex) begin
                if (cnt == CNT_MAX) begin
                  bad = 1'b1; bad_code = E_OVF;
                end else begin
                  src1_nxt = (src1 << 4) | OPW'(nib);
                  cnt_nxt  = cnt + 1'b1;
                end
              end else if (is_sp) begin
                // Spaces before the first digit are padding; after it they end the operand.
                if (cnt != '0) state_nxt = S_OPER;
              end else if (is_op && cnt != '0) begin
                oper_nxt  = op_code;
                cnt_nxt   = '0;
                state_nxt = S_OP2;
              end else begin
                bad = 1'b1; bad_code = E_CHAR;
              end
            end

            S_OPER: begin
              if (is_op) begin
                oper_nxt  = op_code;
                cnt_nxt   = '0;
                state_nxt = S_OP2;
              end else if (!is_sp) begin
                bad = 1'b1; bad_code = E_CHAR;
              end
            end

            S_OP2: begin
              if (is_hex) begin
                if (cnt == CNT_MAX) begin
                  bad = 1'b1; bad_code = E_OVF;
                end else begin
                  src2_nxt = (src2 << 4) | OPW'(nib);
                  cnt_nxt  = cnt + 1'b1;
                end
              end else if (is_sp) begin
                if (cnt != '0) state_nxt = S_EQ;
              end else if (d == CH_EQ && cnt != '0) begin
                state_nxt = S_DONE;
              end else begin
                bad = 1'b1; bad_code = E_CHAR;
              end
            end

            S_EQ: begin
              if (d == CH_EQ) state_nxt = S_DONE;
              else if (!is_sp) begin bad = 1'b1; bad_code = E_CHAR; end
            end

            default: ;
          endcase
        end else if (TIMEOUT > 0) begin
          // A stalled frame is abandoned straight to IDLE; there is nothing to resync past.
          if (tcnt == T_LAST) begin
            state_nxt    = S_IDLE;
            err_vld_nxt  = 1'b1;
            err_code_nxt = E_TIMEOUT;
          end else begin
            tcnt_nxt = tcnt + 1'b1;
          end
        end
      end
    endcase

    if (idle_rules) begin
      if (d == CH_I) begin
        src1_nxt  = '0;
        src2_nxt  = '0;
        cnt_nxt   = '0;
        state_nxt = S_SP1;
      end else if (!(is_sp || d == CH_CR || d == CH_LF)) begin
        bad = 1'b1; bad_code = E_FORMAT;
      end
    end

    if (bad) begin
      state_nxt    = S_ERR;
      err_vld_nxt  = 1'b1;
      err_code_nxt = bad_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      src1     <= '0;
      src2     <= '0;
      dtype    <= 2'd0;
      oper     <= 3'd0;
      cnt      <= '0;
      tcnt     <= '0;
      err_vld  <= 1'b0;
      err_code <= 3'd0;
    end else begin
      state    <= state_nxt;
      src1     <= src1_nxt;
      src2     <= src2_nxt;
      dtype    <= dtype_nxt;
      oper     <= oper_nxt;
      cnt      <= cnt_nxt;
      tcnt     <= tcnt_nxt;
      err_vld  <= err_vld_nxt;
      err_code <= err_code_nxt;
    end
  end

  assign bus.cmd_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.dtype     = dtype;
  assign bus.operator  = oper;
  assign bus.src1      = src1;
  assign bus.src2      = src2;
  assign bus.err_valid = err_vld;
  assign bus.err_code  = err_code;

endmodule

// File: tb/tb_calc_cmd_parser.sv
module tb_calc_cmd_parser;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  calc_cmd_parser_if #(.DIGITS(4)) bus_if ();

  calc_cmd_parser #(.DIGITS(4), .TIMEOUT(100)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  localparam logic [7:0] C_I = 8'h49, C_SP = 8'h20, C_CR = 8'h0D, C_LF = 8'h0A, C_EQ = 8'h3D;

  typedef struct packed {
    logic        is_err;
    logic [2:0]  code;
    logic [1:0]  dtype;
    logic [2:0]  op;
    logic [15:0] s1;
    logic [15:0] s2;
  } evt_t;

  typedef struct {
    logic [127:0] s;    // frame text, right-justified ASCII
    evt_t         exp;  // the single event the frame must produce
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  bit   rand_rdy = 0;
  evt_t obs_q[$];
  evt_t exp_q[$];
  vec_t tbl[$];

  function automatic evt_t mk_cmd(input logic [1:0] dt, input logic [2:0] op,
                                  input logic [15:0] a, input logic [15:0] b);
    evt_t e;
    e = '0;
    e.dtype = dt; e.op = op; e.s1 = a; e.s2 = b;
    return e;
  endfunction

  function automatic evt_t mk_err(input logic [2:0] c);
    evt_t e;
    e = '0;
    e.is_err = 1'b1; e.code = c;
    return e;
  endfunction

  // Observed events: accepted commands and error pulses, one entry per cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.cmd_valid && bus_if.cmd_ready)
        obs_q.push_back(mk_cmd(bus_if.dtype, bus_if.operator, bus_if.src1, bus_if.src2));
      if (bus_if.err_valid)
        obs_q.push_back(mk_err(bus_if.err_code));
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic check_evt(input string name, input evt_t exp);
    evt_t got;
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL %s: no event observed, expected %h", name, exp);
    end else begin
      got = obs_q.pop_front();
      if (got !== exp) begin
        errors++;
        $display("FAIL %s: got event %h expected %h", name, got, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus_if.cmd_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_data  = b;
    bus_if.rx_valid = 1'b1;
    tick();
    bus_if.rx_valid = 1'b0;
  endtask

  task automatic send_str(input logic [127:0] s);
    bit started;
    started = 0;
    for (int i = 15; i >= 0; i--) begin
      if (started || s[8*i +: 8] != 8'h00) begin
        started = 1;
        send_byte(s[8*i +: 8]);
      end
    end
  endtask

  task automatic add_vec(input logic [127:0] s, input evt_t e);
    vec_t v;
    v.s = s; v.exp = e;
    tbl.push_back(v);
  endtask

  function automatic logic [7:0] hexc(input logic [3:0] n, input bit lower);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    return (lower ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
  endfunction

  function automatic logic [7:0] opchar(input logic [2:0] op);
    case (op)
      3'd1:    return 8'h2B;
      3'd2:    return 8'h2D;
      3'd3:    return 8'h2A;
      default: return 8'h2F;
    endcase
  endfunction

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  fq[$];
    logic [15:0] v1, v2;
    logic [3:0]  nb;
    logic [2:0]  op;
    logic [1:0]  dt;
    logic [7:0]  ch;
    evt_t        ex;
    int          k, w, kind, n;
    bit          found;

    rst = 1'b1;
    bus_if.rx_valid  = 1'b0;
    bus_if.rx_data   = 8'h00;
    bus_if.cmd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("reset_outputs",
          {bus_if.cmd_valid, bus_if.err_valid, bus_if.busy, bus_if.dtype, bus_if.operator,
           bus_if.err_code, bus_if.src1, bus_if.src2}, 64'd0);

    // Table-driven frames, consumer always ready
    add_vec("I S 1A2B+0003=",   mk_cmd(2'b01, 3'b001, 16'h1A2B, 16'h0003));
    add_vec("I u 7  *  f =",    mk_cmd(2'b10, 3'b011, 16'h0007, 16'h000F));
    add_vec("I U 1/2=",         mk_cmd(2'b10, 3'b100, 16'h0001, 16'h0002));
    add_vec("I s 0-FFFF=",      mk_cmd(2'b01, 3'b010, 16'h0000, 16'hFFFF));
    add_vec("I S 12345 9=",     mk_err(3'd3));
    add_vec("I X 1+1=",         mk_err(3'd2));
    add_vec("Q=",               mk_err(3'd1));
    add_vec("I S +1=",          mk_err(3'd4));
    add_vec("I S 1+=\n",        mk_err(3'd4));
    add_vec("\r\n I S abc*DEF=", mk_cmd(2'b01, 3'b011, 16'h0ABC, 16'h0DEF));
    add_vec("IS 1+1=\n",        mk_err(3'd1));
    add_vec("I S 12 3+1=",      mk_err(3'd4));
    add_vec("I S 0001+0=",      mk_cmd(2'b01, 3'b001, 16'h0001, 16'h0000));
    add_vec("I U 00001=",       mk_err(3'd3));

    bus_if.cmd_ready = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      obs_q.delete();
      send_str(tbl[i].s);
      repeat (3) tick();
      check($sformatf("tbl%0d_count", i), obs_q.size(), 1);
      check_evt($sformatf("tbl%0d_event", i), tbl[i].exp);
      check($sformatf("tbl%0d_idle", i), bus_if.busy, 0);
    end

    // Overflow error latency and resync
    send_str("I S 1234");
    @(negedge clk);
    check("ovf_before", bus_if.err_valid, 0);
    send_byte(8'h35);
    @(negedge clk);
    check("ovf_pulse", {bus_if.err_valid, bus_if.err_code}, {1'b1, 3'd3});
    tick();
    @(negedge clk);
    check("ovf_one_cycle", {bus_if.err_valid, bus_if.busy}, 2'b01);
    send_byte(8'h39);
    @(negedge clk);
    check("ovf_discard", bus_if.busy, 1);
    send_byte(C_EQ);
    @(negedge clk);
    check("ovf_resync", bus_if.busy, 0);

    // Held result, overrun, release
    bus_if.cmd_ready = 1'b0;
    send_str("I S 1A2B+0003");
    @(negedge clk);
    check("hold_pre_eq", {bus_if.cmd_valid, bus_if.busy}, 2'b01);
    send_byte(C_EQ);
    @(negedge clk);
    check("hold_latency", {bus_if.cmd_valid, bus_if.dtype, bus_if.operator, bus_if.src1, bus_if.src2},
          {1'b1, 2'b01, 3'b001, 16'h1A2B, 16'h0003});
    repeat (10) tick();
    @(negedge clk);
    check("hold_10", {bus_if.cmd_valid, bus_if.err_valid}, 2'b10);
    send_byte(C_I);
    @(negedge clk);
    check("overrun_pulse", {bus_if.err_valid, bus_if.err_code, bus_if.cmd_valid}, {1'b1, 3'd5, 1'b1});
    tick();
    @(negedge clk);
    check("overrun_retained",
          {bus_if.err_valid, bus_if.cmd_valid, bus_if.dtype, bus_if.operator, bus_if.src1, bus_if.src2},
          {1'b0, 1'b1, 2'b01, 3'b001, 16'h1A2B, 16'h0003});
    bus_if.cmd_ready = 1'b1;
    tick();
    bus_if.cmd_ready = 1'b0;
    @(negedge clk);
    check("release_idle", {bus_if.cmd_valid, bus_if.busy}, 2'b00);

    // Handshake and new frame start in the same cycle
    obs_q.delete();
    send_str("I U 5*6=");
    repeat (2) tick();
    bus_if.cmd_ready = 1'b1;
    send_str("I S 2+3=");
    repeat (3) tick();
    check("same_cycle_count", obs_q.size(), 2);
    check_evt("same_cycle_first", mk_cmd(2'b10, 3'b011, 16'h0005, 16'h0006));
    check_evt("same_cycle_second", mk_cmd(2'b01, 3'b001, 16'h0002, 16'h0003));

    // 99 idle cycles mid-frame are tolerated
    obs_q.delete();
    send_str("I S 1");
    repeat (99) tick();
    send_str("+2=");
    repeat (2) tick();
    check("no_timeout_count", obs_q.size(), 1);
    check_evt("no_timeout_cmd", mk_cmd(2'b01, 3'b001, 16'h0001, 16'h0002));

    // Timeout after 100 idle cycles
    send_str("I S 12");
    k = 0;
    found = 0;
    while (!found && k <= 300) begin
      @(negedge clk);
      if (bus_if.err_valid) found = 1;
      else begin
        @(posedge clk);
        #1;
        k++;
      end
    end
    check("timeout_cycles", k, 100);
    check("timeout_code", {bus_if.err_valid, bus_if.err_code}, {1'b1, 3'd6});
    tick();
    @(negedge clk);
    check("timeout_idle", {bus_if.busy, bus_if.err_valid}, 2'b00);

    // Reset in the middle of operand 2
    send_str("I S 1+2");
    @(negedge clk);
    check("pre_reset_busy", bus_if.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_reset_outputs",
          {bus_if.cmd_valid, bus_if.err_valid, bus_if.busy, bus_if.dtype, bus_if.operator,
           bus_if.err_code, bus_if.src1, bus_if.src2}, 64'd0);
    obs_q.delete();
    send_str("I S F-1=");
    repeat (3) tick();
    check("post_reset_count", obs_q.size(), 1);
    check_evt("post_reset_cmd", mk_cmd(2'b01, 3'b010, 16'h000F, 16'h0001));

    // Random frames: expected outcome is known from how each frame was built
    obs_q.delete();
    exp_q.delete();
    rand_rdy = 1;
    for (int f = 0; f < 150; f++) begin
      fq.delete();
      kind = $urandom_range(0, 9);
      if (kind < 6) begin
        if ($urandom_range(0, 3) == 0) begin
          n = $urandom_range(0, 2);
          fq.push_back(n == 0 ? C_SP : (n == 1 ? C_CR : C_LF));
        end
        fq.push_back(C_I);
        fq.push_back(C_SP);
        dt = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
        ch = (dt == 2'b10) ? 8'h55 : 8'h53;
        if ($urandom_range(0, 1) == 1) ch = ch + 8'h20;
        fq.push_back(ch);
        fq.push_back(C_SP);
        repeat ($urandom_range(0, 1)) fq.push_back(C_SP);
        v1 = '0;
        repeat ($urandom_range(1, 4)) begin
          nb = 4'($urandom_range(0, 15));
          v1 = (v1 << 4) | {12'h000, nb};
          fq.push_back(hexc(nb, 1'($urandom_range(0, 1))));
        end
        repeat ($urandom_range(0, 2)) fq.push_back(C_SP);
        op = 3'($urandom_range(1, 4));
        fq.push_back(opchar(op));
        repeat ($urandom_range(0, 2)) fq.push_back(C_SP);
        v2 = '0;
        repeat ($urandom_range(1, 4)) begin
          nb = 4'($urandom_range(0, 15));
          v2 = (v2 << 4) | {12'h000, nb};
          fq.push_back(hexc(nb, 1'($urandom_range(0, 1))));
        end
        repeat ($urandom_range(0, 2)) fq.push_back(C_SP);
        fq.push_back(C_EQ);
        ex = mk_cmd(dt, op, v1, v2);
      end else begin
        case (kind)
          6: begin  // fifth digit in operand 1
            fq = '{C_I, C_SP, 8'h53, C_SP};
            repeat (5) fq.push_back(hexc(4'($urandom_range(0, 15)), 1'b0));
            ex = mk_err(3'd3);
          end
          7: begin  // unknown type letter
            fq = '{C_I, C_SP};
            n = $urandom_range(0, 3);
            fq.push_back(n == 0 ? 8'h58 : (n == 1 ? 8'h41 : (n == 2 ? 8'h31 : 8'h21)));
            ex = mk_err(3'd2);
          end
          8: begin  // frame does not start with 'I'
            n = $urandom_range(0, 3);
            fq.push_back(n == 0 ? 8'h4A : (n == 1 ? 8'h78 : (n == 2 ? C_EQ : 8'h2B)));
            ex = mk_err(3'd1);
          end
          default: begin  // illegal character, or operator before any digit
            fq = '{C_I, C_SP, 8'h55, C_SP};
            repeat ($urandom_range(0, 3)) fq.push_back(hexc(4'($urandom_range(0, 15)), 1'b0));
            fq.push_back((fq.size() == 4) ? 8'h2B : 8'h47);
            ex = mk_err(3'd4);
          end
        endcase
        repeat ($urandom_range(0, 3)) begin
          n = $urandom_range(0, 3);
          fq.push_back(n == 0 ? 8'h47 : (n == 1 ? C_SP : (n == 2 ? 8'h31 : C_I)));
        end
        fq.push_back(($urandom_range(0, 1) == 1) ? C_EQ : C_LF);
      end
      exp_q.push_back(ex);
      foreach (fq[j]) begin
        send_byte(fq[j]);
        repeat ($urandom_range(0, 3)) tick();
      end
      w = 0;
      while (bus_if.cmd_valid && w < 200) begin
        tick();
        w++;
      end
      check($sformatf("rand%0d_drained", f), bus_if.cmd_valid, 0);
    end
    rand_rdy = 0;
    repeat (5) tick();
    check("rand_event_count", obs_q.size(), exp_q.size());
    for (int i = 0; exp_q.size() > 0; i++) begin
      check_evt($sformatf("rand_evt%0d", i), exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
